// File: rtl/fsafe_monitor_mc_if.sv
// Purpose: per-channel bus between the TX schedulers and the transmit fail-safe monitor.
// Latency: none (plain signal bundle).
// Backpressure: bp_enb carries per-channel PHY backpressure; the monitor never stalls the bus.
//
// Ports (grouped):
//   txen, bp_enb, clr_fail   scheduler -> monitor, one bit per channel
//   txen_fail                monitor -> gating, channel in FAIL or COOLDOWN
//   any_fail, fail_id        aggregated fail flag and lowest failed channel index
//   fail_cause               per-channel {timeout,bp} cause of the latched fail
// Modports: master = scheduler side, slave = monitor side.
interface fsafe_monitor_mc_if #(
    parameter int NCH = 4
);
    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [NCH-1:0]   txen;
    logic [NCH-1:0]   bp_enb;
    logic [NCH-1:0]   clr_fail;
    logic [NCH-1:0]   txen_fail;
    logic             any_fail;
    logic [IW-1:0]    fail_id;
    logic [2*NCH-1:0] fail_cause;

    modport master (
        output txen, bp_enb, clr_fail,
        input  txen_fail, any_fail, fail_id, fail_cause
    );

    modport slave (
        input  txen, bp_enb, clr_fail,
        output txen_fail, any_fail, fail_id, fail_cause
    );
endinterface

// File: rtl/fsafe_monitor_mc.sv
// Purpose: multi-channel transmit fail-safe monitor; trips a channel after BPLIMIT
//   backpressure cycles during one transmit, with software clear and cooldown.
// Latency: txen_fail rises one cycle after the tripping bp cycle; any_fail/fail_id comb.
// Backpressure: observes bp_enb only; never stalls, inputs accepted every cycle.
//
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   mon (slave)  txen/bp_enb/clr_fail in; txen_fail/any_fail/fail_id/fail_cause out
// Optional feature: define FSAFE_TIMEOUT_EN to add a per-channel ACTIVE-duration
//   limit of TXLIMIT cycles (fail cause bit timeout). Undefined: timeout bits are 0.
module fsafe_monitor_mc #(
    parameter int NCH      = 4,
    parameter int BPLIMIT  = 512,
    parameter int CONSEC   = 0,
    parameter int COOLDOWN = 16,
    parameter int TXLIMIT  = 4096
) (
    input  logic              clk,
    input  logic              rst,
    fsafe_monitor_mc_if.slave mon
);
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CW  = $clog2(BPLIMIT + 1);
    localparam int CDW = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
    localparam logic [CW-1:0]  BP_LAST = CW'(BPLIMIT - 1);
    localparam logic [CDW-1:0] CD_LAST = CDW'(COOLDOWN - 1);

    generate
        if (NCH < 1 || BPLIMIT < 1 || COOLDOWN < 1 || TXLIMIT < 1) begin : g_param_check
            $error("fsafe_monitor_mc: NCH, BPLIMIT, COOLDOWN and TXLIMIT must all be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FAIL   = 2'd2,
        ST_COOL   = 2'd3
    } state_t;

    state_t         state_q [NCH];
    state_t         state_d [NCH];
    logic [CW-1:0]  bpcnt_q [NCH];
    logic [CW-1:0]  bpcnt_d [NCH];
    logic [CDW-1:0] cdcnt_q [NCH];
    logic [CDW-1:0] cdcnt_d [NCH];
    logic [1:0]     cause_q [NCH];
    logic [1:0]     cause_d [NCH];
    // arm: txen has been seen low since the last clear, so a high txen is a new transmit
    logic [NCH-1:0] arm_q;
    logic [NCH-1:0] arm_d;

    logic [NCH-1:0] bp_trip;
    logic [NCH-1:0] to_trip;
    logic [NCH-1:0] fail_vec;

`ifdef FSAFE_TIMEOUT_EN
    localparam int DW = $clog2(TXLIMIT + 1);
    localparam logic [DW-1:0] TX_LAST = DW'(TXLIMIT - 1);
    logic [DW-1:0] durcnt_q [NCH];
    logic [DW-1:0] durcnt_d [NCH];
`endif

    // Trip conditions are evaluated ahead of the txen check so that the cycle
    // completing the limit fails the channel even if txen drops in that same cycle.
    always_comb begin
        bp_trip = '0;
        to_trip = '0;
        for (int c = 0; c < NCH; c++) begin
            bp_trip[c] = (state_q[c] == ST_ACTIVE) && mon.bp_enb[c] && (bpcnt_q[c] == BP_LAST);
`ifdef FSAFE_TIMEOUT_EN
            to_trip[c] = (state_q[c] == ST_ACTIVE) && (durcnt_q[c] == TX_LAST);
`endif
        end
    end

    // State and counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NCH; c++) begin
                state_q[c] <= ST_IDLE;
                bpcnt_q[c] <= '0;
                cdcnt_q[c] <= '0;
                cause_q[c] <= '0;
`ifdef FSAFE_TIMEOUT_EN
                durcnt_q[c] <= '0;
`endif
            end
            arm_q <= '1;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                state_q[c] <= state_d[c];
                bpcnt_q[c] <= bpcnt_d[c];
                cdcnt_q[c] <= cdcnt_d[c];
                cause_q[c] <= cause_d[c];
`ifdef FSAFE_TIMEOUT_EN
                durcnt_q[c] <= durcnt_d[c];
`endif
            end
            arm_q <= arm_d;
        end
    end

    // Next-state and counter update, one independent FSM per channel
    always_comb begin
        arm_d = arm_q;
        for (int c = 0; c < NCH; c++) begin
            state_d[c] = state_q[c];
            bpcnt_d[c] = bpcnt_q[c];
            cdcnt_d[c] = cdcnt_q[c];
            cause_d[c] = cause_q[c];
`ifdef FSAFE_TIMEOUT_EN
            durcnt_d[c] = durcnt_q[c];
`endif
            case (state_q[c])
                ST_IDLE: begin
                    bpcnt_d[c] = '0;
                    if (!mon.txen[c]) begin
                        arm_d[c] = 1'b1;
                    end else if (arm_q[c]) begin
                        state_d[c] = ST_ACTIVE;
`ifdef FSAFE_TIMEOUT_EN
                        durcnt_d[c] = '0;
`endif
                    end
                end
                ST_ACTIVE: begin
                    if (bp_trip[c] || to_trip[c]) begin
                        state_d[c] = ST_FAIL;
                        cause_d[c] = {to_trip[c], bp_trip[c]};
                        bpcnt_d[c] = '0;
                    end else if (!mon.txen[c]) begin
                        state_d[c] = ST_IDLE;
                        bpcnt_d[c] = '0;
                        arm_d[c]   = 1'b1;
                    end else begin
                        if (mon.bp_enb[c]) begin
                            if (bpcnt_q[c] < BP_LAST) begin
                                bpcnt_d[c] = bpcnt_q[c] + CW'(1);
                            end
                        end else if (CONSEC != 0) begin
                            bpcnt_d[c] = '0;
                        end
`ifdef FSAFE_TIMEOUT_EN
                        if (durcnt_q[c] < TX_LAST) begin
                            durcnt_d[c] = durcnt_q[c] + DW'(1);
                        end
`endif
                    end
                end
                ST_FAIL: begin
                    if (mon.clr_fail[c]) begin
                        state_d[c] = ST_COOL;
                        cdcnt_d[c] = '0;
                        // a txen still high from the failed transmit must not restart it
                        arm_d[c]   = 1'b0;
                    end
                end
                ST_COOL: begin
                    if (!mon.txen[c]) begin
                        arm_d[c] = 1'b1;
                    end
                    if (cdcnt_q[c] == CD_LAST) begin
                        state_d[c] = ST_IDLE;
                        cause_d[c] = '0;
                    end else begin
                        cdcnt_d[c] = cdcnt_q[c] + CDW'(1);
                    end
                end
                default: state_d[c] = ST_IDLE;
            endcase
        end
    end

    // Outputs decoded from the state register; aggregation is combinational
    always_comb begin
        fail_vec = '0;
        for (int c = 0; c < NCH; c++) begin
            fail_vec[c] = (state_q[c] == ST_FAIL) || (state_q[c] == ST_COOL);
        end
        mon.txen_fail = fail_vec;
        mon.any_fail  = |fail_vec;
        // scan downward so the lowest failed index is the last one written
        mon.fail_id = '0;
        for (int c = NCH - 1; c >= 0; c--) begin
            if (fail_vec[c]) begin
                mon.fail_id = IW'(c);
            end
        end
        mon.fail_cause = '0;
        for (int c = 0; c < NCH; c++) begin
            mon.fail_cause[2*c +: 2] = cause_q[c];
        end
    end
endmodule

// File: tb/tb_fsafe_monitor_mc.sv
// Bench for fsafe_monitor_mc: two instances (cumulative and consecutive count mode)
// share one stimulus stream; directed scenarios use hand-derived expectations and the
// random phase compares against a behavioural per-channel model.
module tb_fsafe_monitor_mc;
    localparam int NCH      = 4;
    localparam int BPLIMIT  = 8;
    localparam int COOLDOWN = 16;
    localparam int TXLIMIT  = 20;
`ifdef FSAFE_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] txen = '0;
    logic [3:0] bp   = '0;
    logic [3:0] clr  = '0;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    fsafe_monitor_mc_if #(.NCH(NCH)) if_cum ();
    fsafe_monitor_mc_if #(.NCH(NCH)) if_con ();

    assign if_cum.txen     = txen;
    assign if_cum.bp_enb   = bp;
    assign if_cum.clr_fail = clr;
    assign if_con.txen     = txen;
    assign if_con.bp_enb   = bp;
    assign if_con.clr_fail = clr;

    fsafe_monitor_mc #(.NCH(NCH), .BPLIMIT(BPLIMIT), .CONSEC(0), .COOLDOWN(COOLDOWN),
                       .TXLIMIT(TXLIMIT)) u_cum (.clk(clk), .rst(rst), .mon(if_cum));
    fsafe_monitor_mc #(.NCH(NCH), .BPLIMIT(BPLIMIT), .CONSEC(1), .COOLDOWN(COOLDOWN),
                       .TXLIMIT(TXLIMIT)) u_con (.clk(clk), .rst(rst), .mon(if_con));

    // index 0 = cumulative instance, 1 = consecutive instance
    logic [3:0] o_tf  [2];
    logic       o_any [2];
    logic [1:0] o_id  [2];
    logic [7:0] o_fc  [2];
    assign o_tf[0]  = if_cum.txen_fail;
    assign o_any[0] = if_cum.any_fail;
    assign o_id[0]  = if_cum.fail_id;
    assign o_fc[0]  = if_cum.fail_cause;
    assign o_tf[1]  = if_con.txen_fail;
    assign o_any[1] = if_con.any_fail;
    assign o_id[1]  = if_con.fail_id;
    assign o_fc[1]  = if_con.fail_cause;

    // Behavioural model: per channel, "failed" latch, remaining cooldown cycles,
    // transmit-in-progress flag, bp count, ACTIVE duration and a must-see-low flag.
    bit m_fail [2][NCH];
    int m_cool [2][NCH];
    bit m_on   [2][NCH];
    int m_cnt  [2][NCH];
    int m_dur  [2][NCH];
    bit m_need_low [2][NCH];
    bit m_cbp  [2][NCH];
    bit m_cto  [2][NCH];

    task automatic model_step();
        bit hb, ht;
        for (int m = 0; m < 2; m++) begin
            for (int c = 0; c < NCH; c++) begin
                if (rst) begin
                    m_fail[m][c] = 0; m_cool[m][c] = 0; m_on[m][c] = 0; m_cnt[m][c] = 0;
                    m_dur[m][c] = 0; m_need_low[m][c] = 0; m_cbp[m][c] = 0; m_cto[m][c] = 0;
                end else if (m_cool[m][c] > 0) begin
                    if (!txen[c]) m_need_low[m][c] = 0;
                    m_cool[m][c] = m_cool[m][c] - 1;
                    if (m_cool[m][c] == 0) begin
                        m_cbp[m][c] = 0;
                        m_cto[m][c] = 0;
                    end
                end else if (m_fail[m][c]) begin
                    if (clr[c]) begin
                        m_fail[m][c] = 0;
                        m_cool[m][c] = COOLDOWN;
                        m_need_low[m][c] = 1;
                    end
                end else if (m_on[m][c]) begin
                    hb = bp[c] && (m_cnt[m][c] + 1 >= BPLIMIT);
                    ht = TO_EN && (m_dur[m][c] + 1 >= TXLIMIT);
                    if (hb || ht) begin
                        m_fail[m][c] = 1; m_on[m][c] = 0; m_cnt[m][c] = 0;
                        m_cbp[m][c] = hb; m_cto[m][c] = ht;
                    end else if (!txen[c]) begin
                        m_on[m][c] = 0; m_cnt[m][c] = 0;
                    end else begin
                        if (bp[c]) m_cnt[m][c] = m_cnt[m][c] + 1;
                        else if (m == 1) m_cnt[m][c] = 0;
                        m_dur[m][c] = m_dur[m][c] + 1;
                    end
                end else begin
                    m_cnt[m][c] = 0;
                    if (!txen[c]) m_need_low[m][c] = 0;
                    else if (!m_need_low[m][c]) begin
                        m_on[m][c] = 1;
                        m_dur[m][c] = 0;
                    end
                end
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst = 1; txen = '0; bp = '0; clr = '0;
        cycle(); cycle();
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1; txen = 4'hF; bp = 4'hF; clr = 4'hF;
        cycle(); cycle();
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (o_tf[d] !== 4'b0) $display("FAIL reset_txen_fail dut%0d: got %b want 0000", d, o_tf[d]);
            else n_pass++;
            n_checks++;
            if (o_any[d] !== 1'b0) $display("FAIL reset_any_fail dut%0d: got %b want 0", d, o_any[d]);
            else n_pass++;
            n_checks++;
            if (o_id[d] !== 2'd0) $display("FAIL reset_fail_id dut%0d: got %0d want 0", d, o_id[d]);
            else n_pass++;
            n_checks++;
            if (o_fc[d] !== 8'h00) $display("FAIL reset_fail_cause dut%0d: got %h want 00", d, o_fc[d]);
            else n_pass++;
        end
        rst = 0; txen = '0; bp = '0; clr = '0;
        cycle();
    endtask

    task automatic test_bp_trip();
        do_reset();
        txen = 4'b0010; cycle();
        bp = 4'b0010; repeat (7) cycle();
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (o_tf[d] !== 4'b0000) $display("FAIL trip_before_limit dut%0d: got %b want 0000", d, o_tf[d]);
            else n_pass++;
        end
        cycle();
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (o_tf[d] !== 4'b0010) $display("FAIL trip_txen_fail dut%0d: got %b want 0010", d, o_tf[d]);
            else n_pass++;
            n_checks++;
            if (o_any[d] !== 1'b1) $display("FAIL trip_any_fail dut%0d: got %b want 1", d, o_any[d]);
            else n_pass++;
            n_checks++;
            if (o_id[d] !== 2'd1) $display("FAIL trip_fail_id dut%0d: got %0d want 1", d, o_id[d]);
            else n_pass++;
            n_checks++;
            if (o_fc[d][3:2] !== 2'b01) $display("FAIL trip_cause dut%0d: got %b want 01", d, o_fc[d][3:2]);
            else n_pass++;
        end
        bp = '0; txen = '0;
    endtask

    task automatic test_consec();
        do_reset();
        txen = 4'b0001; cycle();
        bp = 4'b0001; repeat (7) cycle();
        bp = 4'b0000; cycle();
        bp = 4'b0001; cycle();
        n_checks++;
        if (o_tf[0][0] !== 1'b1) $display("FAIL cumulative_trip: got %b want 1", o_tf[0][0]);
        else n_pass++;
        n_checks++;
        if (o_tf[1][0] !== 1'b0) $display("FAIL consec_gap_reset: got %b want 0", o_tf[1][0]);
        else n_pass++;
        repeat (6) cycle();
        n_checks++;
        if (o_tf[1][0] !== 1'b0) $display("FAIL consec_seven_run: got %b want 0", o_tf[1][0]);
        else n_pass++;
        cycle();
        n_checks++;
        if (o_tf[1][0] !== 1'b1) $display("FAIL consec_eight_run: got %b want 1", o_tf[1][0]);
        else n_pass++;
        bp = '0; txen = '0;
    endtask

    task automatic test_multi();
        do_reset();
        txen = 4'b0101; cycle();
        bp = 4'b0101; repeat (8) cycle();
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (o_tf[d] !== 4'b0101 || o_id[d] !== 2'd0)
                $display("FAIL multi_trip dut%0d: got tf=%b id=%0d want tf=0101 id=0", d, o_tf[d], o_id[d]);
            else n_pass++;
        end
        bp = '0; txen = '0; clr = 4'b0001; cycle();
        clr = '0;
        repeat (15) cycle();
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (o_tf[d] !== 4'b0101 || o_id[d] !== 2'd0)
                $display("FAIL cooldown_hold dut%0d: got tf=%b id=%0d want tf=0101 id=0", d, o_tf[d], o_id[d]);
            else n_pass++;
        end
        cycle();
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (o_tf[d] !== 4'b0100 || o_id[d] !== 2'd2)
                $display("FAIL cooldown_exit dut%0d: got tf=%b id=%0d want tf=0100 id=2", d, o_tf[d], o_id[d]);
            else n_pass++;
            n_checks++;
            if (o_fc[d] !== 8'b0001_0000) $display("FAIL cooldown_cause dut%0d: got %b want 00010000", d, o_fc[d]);
            else n_pass++;
        end
    endtask

    task automatic test_edge();
        do_reset();
        txen = 4'b1000; cycle();
        bp = 4'b1000; repeat (7) cycle();
        txen = 4'b0000; cycle();
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (o_tf[d] !== 4'b1000 || o_fc[d][7:6] !== 2'b01)
                $display("FAIL trip_with_txen_low dut%0d: got tf=%b cause=%b want 1000/01", d, o_tf[d], o_fc[d][7:6]);
            else n_pass++;
        end
        do_reset();
        txen = 4'b1000; cycle();
        bp = 4'b1000; repeat (5) cycle();
        txen = '0; bp = '0; cycle();
        txen = 4'b1000; cycle();
        bp = 4'b1000; repeat (7) cycle();
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (o_tf[d] !== 4'b0000) $display("FAIL count_cleared_on_drop dut%0d: got %b want 0000", d, o_tf[d]);
            else n_pass++;
        end
        cycle();
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (o_tf[d] !== 4'b1000) $display("FAIL fresh_trip dut%0d: got %b want 1000", d, o_tf[d]);
            else n_pass++;
        end
        bp = '0; txen = '0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        txen = 4'b0110; cycle();
        bp = 4'b0110; repeat (8) cycle();
        bp = '0; txen = '0; clr = 4'b0100; cycle();
        clr = '0; repeat (3) cycle();
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (o_tf[d] !== 4'b0110) $display("FAIL pre_reset_state dut%0d: got %b want 0110", d, o_tf[d]);
            else n_pass++;
        end
        rst = 1; cycle();
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (o_tf[d] !== 4'b0 || o_any[d] !== 1'b0 || o_id[d] !== 2'd0 || o_fc[d] !== 8'h00)
                $display("FAIL mid_reset dut%0d: got tf=%b any=%b id=%0d fc=%h want all 0",
                         d, o_tf[d], o_any[d], o_id[d], o_fc[d]);
            else n_pass++;
        end
        rst = 0;
        txen = 4'b0010; cycle();
        bp = 4'b0010; clr = 4'b0010; repeat (7) cycle();
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (o_tf[d] !== 4'b0000) $display("FAIL clr_while_active dut%0d: got %b want 0000", d, o_tf[d]);
            else n_pass++;
        end
        clr = '0; cycle();
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (o_tf[d] !== 4'b0010) $display("FAIL trip_after_reset dut%0d: got %b want 0010", d, o_tf[d]);
            else n_pass++;
        end
        bp = '0; txen = '0;
    endtask

    task automatic test_timeout();
        logic [3:0] exp_tf;
        logic [1:0] exp_c;
        exp_tf = TO_EN ? 4'b0001 : 4'b0000;
        exp_c  = TO_EN ? 2'b10 : 2'b00;
        do_reset();
        txen = 4'b0001; cycle();
        repeat (19) cycle();
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (o_tf[d] !== 4'b0000) $display("FAIL timeout_early dut%0d: got %b want 0000", d, o_tf[d]);
            else n_pass++;
        end
        cycle();
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (o_tf[d] !== exp_tf || o_fc[d][1:0] !== exp_c)
                $display("FAIL timeout dut%0d: got tf=%b cause=%b want %b/%b", d, o_tf[d], o_fc[d][1:0], exp_tf, exp_c);
            else n_pass++;
        end
        txen = '0;
    endtask

    task automatic test_random();
        logic [3:0] e_tf;
        logic [7:0] e_fc;
        logic [1:0] e_id;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 11) == 0) txen[c] = ~txen[c];
                bp[c]  = ($urandom_range(0, 9) < 6);
                clr[c] = ($urandom_range(0, 7) == 0);
            end
            rst = ($urandom_range(0, 599) == 0);
            cycle();
            for (int d = 0; d < 2; d++) begin
                e_tf = '0; e_fc = '0; e_id = '0;
                for (int c = 0; c < NCH; c++) begin
                    e_tf[c] = m_fail[d][c] || (m_cool[d][c] > 0);
                    e_fc[2*c]   = m_cbp[d][c];
                    e_fc[2*c+1] = m_cto[d][c];
                end
                for (int c = NCH - 1; c >= 0; c--) if (e_tf[c]) e_id = 2'(c);
                n_checks++;
                if (o_tf[d] !== e_tf || o_any[d] !== (|e_tf) || o_id[d] !== e_id || o_fc[d] !== e_fc)
                    $display("FAIL random cyc%0d dut%0d: got tf=%b any=%b id=%0d fc=%b want tf=%b any=%b id=%0d fc=%b",
                             i, d, o_tf[d], o_any[d], o_id[d], o_fc[d], e_tf, |e_tf, e_id, e_fc);
                else n_pass++;
            end
        end
        rst = 0; txen = '0; bp = '0; clr = '0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_bp_trip();
        test_consec();
        test_multi();
        test_edge();
        test_reset_mid();
        test_timeout();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
